// File: rtl/cpu_controller.sv
// Multi-cycle control FSM for the 16-bit accumulator CPU: sequences fetch, decode,
// execute and write-back and drives all datapath selects, enables and memory strobes.
module cpu_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic [8:0] func,
  output logic       PcWrite,
  output logic       branch,
  output logic       IorD,
  output logic       IRWrite,
  output logic       regDst,
  output logic       moveTo,
  output logic       dataFromMem,
  output logic       noOp,
  output logic       regWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PcSrc,
  output logic [2:0] ALUopc,
  output logic       memRead,
  output logic       memWrite,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    LD_MEM = 4'd2,
    LD_WB  = 4'd3,
    ST     = 4'd4,
    JMP    = 4'd5,
    BRZ    = 4'd6,
    C_EX   = 4'd7,
    C_WB   = 4'd8,
    I_EX   = 4'd9,
    I_WB   = 4'd10
  } stateT;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_BZ    = 4'b0100;
  localparam logic [3:0] OP_CTYPE = 4'b1000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOTA  = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;
  localparam logic [2:0] ALU_PASSA = 3'b110;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_BRANCH  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;

  stateT curState;
  stateT nxtState;

  // A C-type function is executable only when exactly one of bits 0..6 is set.
  function automatic logic cFuncIsNop(input logic [8:0] f);
    logic [6:0] low;
    low = f[6:0];
    return f[8] | f[7] | (low == 7'd0) | ((low & (low - 7'd1)) != 7'd0);
  endfunction

  function automatic logic [2:0] cFuncOp(input logic [8:0] f);
    logic [2:0] op;
    op = ALU_ADD;
    if (!cFuncIsNop(f)) begin
      unique case (1'b1)
        f[0]:    op = ALU_PASSA;
        f[1]:    op = ALU_PASSB;
        f[2]:    op = ALU_ADD;
        f[3]:    op = ALU_SUB;
        f[4]:    op = ALU_AND;
        f[5]:    op = ALU_OR;
        f[6]:    op = ALU_NOTA;
        default: op = ALU_ADD;
      endcase
    end
    return op;
  endfunction

  function automatic logic [2:0] immOp(input logic [1:0] sel);
    logic [2:0] op;
    unique case (sel)
      2'b00:   op = ALU_ADD;
      2'b01:   op = ALU_SUB;
      2'b10:   op = ALU_AND;
      default: op = ALU_OR;
    endcase
    return op;
  endfunction

  function automatic stateT decodeNext(input logic [3:0] op);
    stateT ns;
    if (op[3:2] == 2'b11) begin
      ns = I_EX;
    end else begin
      unique case (op)
        OP_LOAD:  ns = LD_MEM;
        OP_STORE: ns = ST;
        OP_JUMP:  ns = JMP;
        OP_BZ:    ns = BRZ;
        OP_CTYPE: ns = C_EX;
        default:  ns = FETCH;
      endcase
    end
    return ns;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) curState <= FETCH;
    else     curState <= nxtState;
  end

  assign state = curState;

  always_comb begin
    nxtState    = FETCH;
    PcWrite     = 1'b0;
    branch      = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    regDst      = 1'b0;
    moveTo      = 1'b0;
    dataFromMem = 1'b0;
    noOp        = 1'b0;
    regWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    PcSrc       = PC_ALU;
    ALUopc      = ALU_ADD;
    memRead     = 1'b0;
    memWrite    = 1'b0;

    unique case (curState)
      FETCH: begin
        memRead  = 1'b1;
        IRWrite  = 1'b1;
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_ONE;
        ALUopc   = ALU_ADD;
        PcSrc    = PC_ALU;
        PcWrite  = 1'b1;
        nxtState = DECODE;
      end
      DECODE: nxtState = decodeNext(opcode);
      LD_MEM: begin
        IorD     = 1'b1;
        memRead  = 1'b1;
        nxtState = LD_WB;
      end
      LD_WB: begin
        dataFromMem = 1'b1;
        regWrite    = 1'b1;
      end
      ST: begin
        IorD     = 1'b1;
        memWrite = 1'b1;
      end
      JMP: begin
        PcSrc   = PC_JUMP;
        PcWrite = 1'b1;
      end
      // PC is only updated by the datapath when the pass-A result is zero.
      BRZ: begin
        ALUopc = ALU_PASSA;
        PcSrc  = PC_BRANCH;
        branch = 1'b1;
      end
      C_EX: begin
        ALUSrcB  = SRCB_REG;
        ALUopc   = cFuncOp(func);
        nxtState = C_WB;
      end
      C_WB: begin
        regWrite = 1'b1;
        if (cFuncIsNop(func)) begin
          noOp = 1'b1;
        end else if (func[0]) begin
          moveTo = 1'b1;
          regDst = 1'b1;
        end
      end
      I_EX: begin
        ALUSrcB  = SRCB_IMM;
        ALUopc   = immOp(opcode[1:0]);
        nxtState = I_WB;
      end
      I_WB: regWrite = 1'b1;
      default: nxtState = FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: walks each instruction class through its state
// sequence and compares the state and every control output against hand-written values.
module tb_cpu_controller;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic [8:0] func;
  logic       PcWrite, branch, IorD, IRWrite, regDst, moveTo, dataFromMem, noOp;
  logic       regWrite, ALUSrcA, memRead, memWrite;
  logic [1:0] ALUSrcB, PcSrc;
  logic [2:0] ALUopc;
  logic [3:0] state;

  int nCompared;
  int nMismatched;

  cpu_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .PcWrite(PcWrite), .branch(branch), .IorD(IorD), .IRWrite(IRWrite),
    .regDst(regDst), .moveTo(moveTo), .dataFromMem(dataFromMem), .noOp(noOp),
    .regWrite(regWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PcSrc(PcSrc),
    .ALUopc(ALUopc), .memRead(memRead), .memWrite(memWrite), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] ctlVec;
  assign ctlVec = {PcWrite, branch, IorD, IRWrite, regDst, moveTo, dataFromMem, noOp,
                   regWrite, ALUSrcA, ALUSrcB, PcSrc, ALUopc, memRead, memWrite};

  function automatic logic [18:0] ctl(
    input logic pcw, input logic br, input logic iord, input logic irw,
    input logic rd, input logic mt, input logic dfm, input logic nop,
    input logic rw, input logic asa, input logic [1:0] asb, input logic [1:0] pcs,
    input logic [2:0] op, input logic mr, input logic mw);
    return {pcw, br, iord, irw, rd, mt, dfm, nop, rw, asa, asb, pcs, op, mr, mw};
  endfunction

  localparam logic [18:0] C_FETCH  = ctl(1,0,0,1,0,0,0,0,0,1,2'b01,2'b00,3'b000,1,0);
  localparam logic [18:0] C_NONE   = 19'd0;
  localparam logic [18:0] C_LDMEM  = ctl(0,0,1,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,1,0);
  localparam logic [18:0] C_LDWB   = ctl(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,0);
  localparam logic [18:0] C_ST     = ctl(0,0,1,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,1);
  localparam logic [18:0] C_JMP    = ctl(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0,0);
  localparam logic [18:0] C_BRZ    = ctl(0,1,0,0,0,0,0,0,0,0,2'b00,2'b01,3'b110,0,0);
  localparam logic [18:0] C_WBREG  = ctl(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0,0);
  localparam logic [18:0] C_WBMOVE = ctl(0,0,0,0,1,1,0,0,1,0,2'b00,2'b00,3'b000,0,0);
  localparam logic [18:0] C_WBNOP  = ctl(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0,0);

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compares at the current falling edge, then advances one clock.
  task automatic cyc(input string tag, input logic [3:0] expState, input logic [18:0] expCtl);
    checkVal({tag, ".state"}, {28'd0, state}, {28'd0, expState});
    checkVal({tag, ".ctl"}, {13'd0, ctlVec}, {13'd0, expCtl});
    @(negedge clk);
  endtask

  logic [3:0]  immOpc [4];
  logic [2:0]  immAlu [4];
  logic [8:0]  cFunc  [8];
  logic [2:0]  cAlu   [8];
  logic [18:0] cWb    [8];
  logic [3:0]  badOpc [4];

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst    = 1'b1;
    opcode = 4'h0;
    func   = 9'h000;

    immOpc = '{4'hC, 4'hD, 4'hE, 4'hF};
    immAlu = '{3'b000, 3'b001, 3'b010, 3'b011};
    cFunc  = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h080};
    cAlu   = '{3'b110, 3'b101, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
    cWb    = '{C_WBMOVE, C_WBREG, C_WBREG, C_WBREG, C_WBREG, C_WBREG, C_WBREG, C_WBNOP};
    badOpc = '{4'h3, 4'h5, 4'h9, 4'hB};

    repeat (2) @(negedge clk);
    checkVal("reset.state", {28'd0, state}, 32'd0);
    checkVal("reset.ctl", {13'd0, ctlVec}, {13'd0, C_FETCH});
    rst = 1'b0;

    opcode = 4'h0;
    cyc("load.f", 4'd0, C_FETCH);
    cyc("load.d", 4'd1, C_NONE);
    cyc("load.mem", 4'd2, C_LDMEM);
    cyc("load.wb", 4'd3, C_LDWB);

    opcode = 4'h1;
    cyc("store.f", 4'd0, C_FETCH);
    cyc("store.d", 4'd1, C_NONE);
    cyc("store.st", 4'd4, C_ST);

    for (int i = 0; i < 4; i++) begin
      opcode = immOpc[i];
      cyc("imm.f", 4'd0, C_FETCH);
      cyc("imm.d", 4'd1, C_NONE);
      cyc("imm.ex", 4'd9, ctl(0,0,0,0,0,0,0,0,0,0,2'b10,2'b00,immAlu[i],0,0));
      cyc("imm.wb", 4'd10, C_WBREG);
    end

    opcode = 4'h4;
    cyc("bz.f", 4'd0, C_FETCH);
    cyc("bz.d", 4'd1, C_NONE);
    cyc("bz.brz", 4'd6, C_BRZ);

    opcode = 4'h8;
    for (int i = 0; i < 8; i++) begin
      func = cFunc[i];
      cyc("ctype.f", 4'd0, C_FETCH);
      cyc("ctype.d", 4'd1, C_NONE);
      cyc("ctype.ex", 4'd7, ctl(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,cAlu[i],0,0));
      cyc("ctype.wb", 4'd8, cWb[i]);
    end
    func = 9'h003;
    cyc("ctype2b.f", 4'd0, C_FETCH);
    cyc("ctype2b.d", 4'd1, C_NONE);
    cyc("ctype2b.ex", 4'd7, C_NONE);
    cyc("ctype2b.wb", 4'd8, C_WBNOP);
    func = 9'h104;
    cyc("ctype8.f", 4'd0, C_FETCH);
    cyc("ctype8.d", 4'd1, C_NONE);
    cyc("ctype8.ex", 4'd7, C_NONE);
    cyc("ctype8.wb", 4'd8, C_WBNOP);
    func = 9'h000;
    cyc("ctype0.f", 4'd0, C_FETCH);
    cyc("ctype0.d", 4'd1, C_NONE);
    cyc("ctype0.ex", 4'd7, C_NONE);
    cyc("ctype0.wb", 4'd8, C_WBNOP);

    // Opcode bus holds garbage during FETCH; only its value in DECODE matters.
    opcode = 4'h3;
    cyc("jump.f", 4'd0, C_FETCH);
    opcode = 4'h2;
    cyc("jump.d", 4'd1, C_NONE);
    cyc("jump.jmp", 4'd5, C_JMP);

    for (int i = 0; i < 4; i++) begin
      opcode = badOpc[i];
      cyc("undef.f", 4'd0, C_FETCH);
      cyc("undef.d", 4'd1, C_NONE);
    end

    opcode = 4'h0;
    cyc("ldrst.f", 4'd0, C_FETCH);
    cyc("ldrst.d", 4'd1, C_NONE);
    checkVal("ldrst.mem.state", {28'd0, state}, 32'd2);
    #2 rst = 1'b1;
    #1;
    checkVal("asyncrst.state", {28'd0, state}, 32'd0);
    checkVal("asyncrst.ctl", {13'd0, ctlVec}, {13'd0, C_FETCH});
    @(negedge clk);
    checkVal("rsthold.state", {28'd0, state}, 32'd0);
    checkVal("rsthold.regWrite", {31'd0, regWrite}, 32'd0);
    rst = 1'b0;
    cyc("restart.f", 4'd0, C_FETCH);
    cyc("restart.d", 4'd1, C_NONE);
    cyc("restart.mem", 4'd2, C_LDMEM);
    cyc("restart.wb", 4'd3, C_LDWB);
    cyc("final.f", 4'd0, C_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle control unit for the 16-bit accumulator CPU datapath: a Moore-style FSM (with IR-field decoding in selected states) that sequences fetch, decode, execute and write-back, and drives every datapath select, write-enable and ALU-opcode line plus the memory read/write strobes. It sits beside the datapath, consumes `opcode`/`func` from the instruction register, and together with the datapath and the memory forms the CPU top level. R0 is the accumulator (register-file port readData0 -> A); Ri = R[inst[11:9]] (readData1 -> B).

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high; forces state to FETCH
- opcode  in  4  inst[15:12] from IR
- func  in  9  inst[8:0] from IR (one-hot C-type function field)
- PcWrite, branch, IorD, IRWrite, regDst, moveTo, dataFromMem, noOp, regWrite, ALUSrcA  out  1 each  datapath controls
- ALUSrcB  out  2  00 B, 01 const 1, 10 sext(inst[11:0])
- PcSrc  out  2  00 ALU result, 01 {PC[11:9],inst[8:0]}, 10 inst[11:0]
- ALUopc  out  3  000 add, 001 sub, 010 and, 011 or, 100 not A, 101 pass B, 110 pass A
- memRead, memWrite  out  1 each  memory strobes
- state  out  4  current state encoding (debug/verification)

## Operation
- Every output not listed for a state is 0 (ALUSrcB/PcSrc/ALUopc = 000/00).
- Opcodes: 0000 LOAD R0<-M[a12]; 0001 STORE M[a12]<-R0; 0010 JUMP PC<-a12; 0100 BZ if R0==0 PC<-{PC[11:9],inst[8:0]}; 1000 C-type; 1100 ADDI, 1101 SUBI, 1110 ANDI, 1111 ORI (R0<-R0 op sext(a12)); all others undefined.
- C-type func one-hot: bit0 MOVETO Ri<-R0; bit1 MOVEFROM R0<-Ri; bit2 ADD; bit3 SUB; bit4 AND; bit5 OR (R0<-R0 op Ri); bit6 NOT R0<-~R0; bit7 NOP. Zero or multiple bits set, or bit8 set -> treated as NOP.
- States (encoding in parentheses):
- FETCH (0): IorD=0, memRead, IRWrite, ALUSrcA=1, ALUSrcB=01, ALUopc=add, PcSrc=00, PcWrite -> DECODE.
- DECODE (1): no controls; A/B load from new IR. Next: LOAD->LD_MEM, STORE->ST, JUMP->JMP, BZ->BRZ, C-type->C_EX, imm->I_EX, undefined->FETCH.
- LD_MEM (2): IorD=1, memRead -> LD_WB. LD_WB (3): dataFromMem=1, regWrite -> FETCH.
- ST (4): IorD=1, memWrite -> FETCH.
- JMP (5): PcSrc=10, PcWrite -> FETCH.
- BRZ (6): ALUSrcA=0, ALUopc=pass A, PcSrc=01, branch=1 -> FETCH (PC updates only if ALU zero).
- C_EX (7): ALUSrcA=0, ALUSrcB=00, ALUopc from func (MOVETO pass A, MOVEFROM pass B, ADD/SUB/AND/OR, NOT; NOP add) -> C_WB.
- C_WB (8): regWrite=1, dataFromMem=0; MOVETO: moveTo=1, regDst=1; NOP/invalid func: noOp=1 -> FETCH.
- I_EX (9): ALUSrcA=0, ALUSrcB=10, ALUopc = add/sub/and/or for 1100/1101/1110/1111 -> I_WB. I_WB (10): regWrite, dataFromMem=0 -> FETCH.
- Encodings 11-15 unreachable; if entered, next state FETCH with all outputs 0.

## Timing
- During and after reset: state=0 (FETCH), outputs equal FETCH values; first fetch completes on first rising edge after rst deasserts.
- Outputs are combinational from state (and IR fields in DECODE transition, BRZ, C_EX, C_WB, I_EX); glitch-free relative to the clock edge they are sampled on.
- Cycles per instruction: LOAD 4, STORE 3, JUMP 3, BZ 3, C-type 4, immediate 4, undefined 2.
- PC increments at end of FETCH; JMP/BRZ overwrite the incremented PC.
- rst asserted mid-instruction: state goes to FETCH immediately; partially executed instruction has no further writes.
- opcode/func are only used after DECODE; changes while in FETCH are ignored.

## Test plan
- Reset, then M[0]=0x0005 (LOAD 5), M[5]=0x1234 -> state 0,1,2,3,0; R0=0x1234 after 4 cycles; PC=1.
- STORE 0x1020 with R0=0x00AB -> memWrite high exactly 1 cycle in state 4, M[0x020]=0x00AB; no regWrite.
- ADDI 0xCFFF with R0=3 -> R0=2 (sext -1); SUBI 0xD002 -> R0=0; then BZ 0x4010 at PC=0x203 -> PC=0x210; with R0=1 BZ leaves PC=next address.
- C-type 0x8601 (MOVETO R3) with R0=0x77 -> moveTo=regDst=1 in C_WB, R3=0x77, R0 unchanged; 0x8680 (NOP) -> noOp=1, no register changes; 0x8003 (two bits) -> behaves as NOP.
- JUMP 0x2ABC -> PC=0xABC after 3 cycles; opcode 0x3 -> DECODE->FETCH, no writes, PC+1 only.
- rst pulsed while in LD_MEM -> state 0 asynchronously, R0 not written, fetch restarts at PC=0.
